// File: rtl/booth_pkg.sv
// Shared constants for the radix-2 Booth multiplier: state encoding,
// operand width, iteration count and Booth pair codes.
package booth_pkg;

  localparam int BOOTH_W   = 8;
  localparam int ITER      = 8;
  localparam int ITER_CNTW = 3;

  // Control FSM encoding (2 bits)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Booth pair {Q[0], Qm1}: 01 adds M, 10 subtracts M, 00/11 only shift
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // True when a 16-bit product does not fit a signed 8-bit result
  function automatic logic prod_exceeds_s8(input logic [15:0] p);
    prod_exceeds_s8 = (p[15:8] != {8{p[7]}});
  endfunction

endpackage

// File: rtl/booth_mul_8bit_cla.sv
// 8-bit carry-lookahead adder/subtractor (two 4-bit lookahead groups).
// sub=1 computes A-B as A + ~B + 1. Ovfl is signed overflow of the
// 8-bit result; pos/neg flag the sign of Sum.
module CLA_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       sub,
  output logic [7:0] Sum,
  output logic       Cout,
  output logic       Ovfl,
  output logic       pos,
  output logic       neg
);

  logic [7:0] w_b;
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [3:0] w_c_lo;
  logic [3:0] w_c_hi;
  logic [8:0] w_c;

  // Carries c1..c4 of a 4-bit group, fully expanded lookahead terms
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic cin);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    cla4 = c;
  endfunction

  assign w_b    = B ^ {8{sub}};
  assign w_g    = A & w_b;
  assign w_p    = A ^ w_b;
  assign w_c_lo = cla4(w_g[3:0], w_p[3:0], sub);
  assign w_c_hi = cla4(w_g[7:4], w_p[7:4], w_c_lo[3]);
  assign w_c    = {w_c_hi, w_c_lo, sub};

  assign Sum  = w_p ^ w_c[7:0];
  assign Cout = w_c[8];
  assign Ovfl = w_c[8] ^ w_c[7];
  assign neg  = Sum[7];
  assign pos  = ~Sum[7] & (|Sum);

endmodule

// File: rtl/booth_mul_8bit.sv
// Multi-cycle signed 8x8 -> 16 radix-2 Booth multiplier with valid/ready
// on both sides and one operation in flight. Each RUN cycle drives the
// CLA with A and M; the adder's Ovfl repairs the sign shifted into A, so
// M = -128 stays exact with an 8-bit accumulator.
// Optional feature: define BOOTH_OVFL_EN to add the prod_ovfl output
// (product does not fit signed 8 bits).
module booth_mul_8bit
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
`ifdef BOOTH_OVFL_EN
  ,
  output logic                 prod_ovfl
`endif
);

  if (WIDTH != BOOTH_W) begin : g_bad_width
    $error("booth_mul_8bit: only WIDTH=8 is supported");
  end
  if (CNT_W != ITER_CNTW) begin : g_bad_cntw
    $error("booth_mul_8bit: CNT_W must be 3");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_qm1;
  logic [WIDTH-1:0]   r_m;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_product;

  logic [1:0]         w_code;
  logic               w_sub;
  logic               w_active;
  logic [WIDTH-1:0]   w_cla_sum;
  logic               w_cla_ovfl;
  logic               w_unused_cout;
  logic               w_unused_pos;
  logic               w_unused_neg;
  logic [WIDTH-1:0]   w_sum;
  logic               w_ov;
  logic               w_sgn;
  logic [WIDTH-1:0]   w_a_next;
  logic [WIDTH-1:0]   w_q_next;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_code   = {r_q[0], r_qm1};
  assign w_sub    = (w_code == BOOTH_SUB);
  assign w_active = (w_code == BOOTH_ADD) || (w_code == BOOTH_SUB);

  CLA_8bit u_cla (
    .A    (r_a),
    .B    (r_m),
    .sub  (w_sub),
    .Sum  (w_cla_sum),
    .Cout (w_unused_cout),
    .Ovfl (w_cla_ovfl),
    .pos  (w_unused_pos),
    .neg  (w_unused_neg)
  );

  // One Booth step: pick A+/-M or plain A, then arithmetic-shift {A,Q,Qm1}
  // right with the true 9-bit sign (S[7] corrected by adder overflow)
  always_comb begin
    w_sum = r_a;
    w_ov  = 1'b0;
    if (w_active) begin
      w_sum = w_cla_sum;
      w_ov  = w_cla_ovfl;
    end else begin
      w_sum = r_a;
      w_ov  = 1'b0;
    end
    w_sgn       = w_sum[WIDTH-1] ^ w_ov;
    w_a_next    = {w_sgn, w_sum[WIDTH-1:1]};
    w_q_next    = {w_sum[0], r_q[WIDTH-1:1]};
    w_prod_next = {w_a_next, w_q_next};
  end

  // Control FSM and datapath registers: accept, 8 Booth steps, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_q         <= {WIDTH{1'b0}};
      r_qm1       <= 1'b0;
      r_m         <= {WIDTH{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_product   <= {(2*WIDTH){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= {WIDTH{1'b0}};
            r_q     <= mplr;
            r_qm1   <= 1'b0;
            r_m     <= mcand;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DONE;
            r_product   <= w_prod_next;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign product   = r_product;

`ifdef BOOTH_OVFL_EN
  logic r_prod_ovfl;

  // Narrow-overflow flag: captured with the product, dropped on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_ovfl <= 1'b0;
    end else if ((r_state == ST_RUN) && (r_cnt == CNT_LAST)) begin
      r_prod_ovfl <= prod_exceeds_s8(w_prod_next);
    end else if ((r_state == ST_DONE) && out_ready) begin
      r_prod_ovfl <= 1'b0;
    end else begin
      r_prod_ovfl <= r_prod_ovfl;
    end
  end

  assign prod_ovfl = r_prod_ovfl;
`endif

endmodule
